d_e_issue_ctrl: RTL and testbench

//  Sequences the decode->execute pipeline register: per cycle decides issue, hold or bubble.

---
 rtl/d_e_issue_ctrl_pkg.sv | 24 ++
 rtl/d_e_hazard_unit.sv | 31 +++
 rtl/d_e_issue_ctrl.sv | 147 ++++++++++++++
 tb/tb_d_e_issue_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/d_e_issue_ctrl_pkg.sv
// Shared types for the decode->execute issue controller.
// Issue FSM states, hazard cause codes and a counter width helper.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    MUL_WAIT,
    FLUSH_DRAIN
  } issue_state_t;

  typedef enum logic [2:0] {
    NONE,
    LOAD_USE,
    ROB_FULL,
    MUL_BUSY,
    FLUSHING
  } hazard_cause_t;

  // Width of a down-counter loaded with n-1, at least one bit.
  function automatic int cnt_w(int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/d_e_hazard_unit.sv
// Combinational load-use comparator between decode and execute.
// In: decode sources/uses, execute valid/load/rd. Out: load_use_o.
module d_e_hazard_unit #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  dec_valid_i,
  input  logic [REG_ADDR_W-1:0] dec_rs1_i,
  input  logic [REG_ADDR_W-1:0] dec_rs2_i,
  input  logic                  dec_uses_rs1_i,
  input  logic                  dec_uses_rs2_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_is_load_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  output logic                  load_use_o
);

  logic rd_live;
  logic hit1;
  logic hit2;

  // x0 is never a real producer.
  assign rd_live = ex_valid_i & ex_is_load_i
                 & (ex_rd_i != '0);
  assign hit1 = dec_uses_rs1_i
              & (dec_rs1_i == ex_rd_i);
  assign hit2 = dec_uses_rs2_i
              & (dec_rs2_i == ex_rd_i);
  assign load_use_o = dec_valid_i & rd_live
                    & (hit1 | hit2);

endmodule

// File: rtl/d_e_issue_ctrl.sv
// D/E issue control: issue, hold or bubble per cycle.
// Optional perf counters when D_E_ISSUE_CTRL_PERF_EN is defined.
module d_e_issue_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W    = 5,
  parameter int MUL_LATENCY   = 5,
  parameter int FLUSH_BUBBLES = 1,
  parameter int PERF_CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic                  dec_uses_rs1,
  input  logic                  dec_uses_rs2,
  input  logic                  dec_is_mul,
  input  logic                  ex_valid,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  rob_full,
  input  logic                  flush,
`ifdef D_E_ISSUE_CTRL_PERF_EN
  output logic [PERF_CNT_W-1:0] perf_stall_cycles,
  output logic [PERF_CNT_W-1:0] perf_bubbles,
  output logic [PERF_CNT_W-1:0] perf_mul_wait,
`endif
  output logic                  de_stall,
  output logic                  de_valid,
  output logic                  fd_stall,
  output logic                  rob_alloc
);

  localparam int MUL_W = cnt_w(MUL_LATENCY);
  localparam int DRN_W = cnt_w(FLUSH_BUBBLES);

  issue_state_t     state_q, state_d;
  logic [MUL_W-1:0] mul_cnt_q, mul_cnt_d;
  logic [DRN_W-1:0] drn_cnt_q, drn_cnt_d;
  logic             load_use;
  logic             ds_c, dv_c, fs_c;

  d_e_hazard_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hz (
    .dec_valid_i   (dec_valid),
    .dec_rs1_i     (dec_rs1),
    .dec_rs2_i     (dec_rs2),
    .dec_uses_rs1_i(dec_uses_rs1),
    .dec_uses_rs2_i(dec_uses_rs2),
    .ex_valid_i    (ex_valid),
    .ex_is_load_i  (ex_is_load),
    .ex_rd_i       (ex_rd),
    .load_use_o    (load_use)
  );

  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    drn_cnt_d = drn_cnt_q;
    ds_c      = 1'b0;
    dv_c      = 1'b0;
    fs_c      = 1'b0;
    priority case (1'b1)
      flush: begin
        mul_cnt_d = '0;
        if (FLUSH_BUBBLES > 1) begin
          state_d   = FLUSH_DRAIN;
          drn_cnt_d = DRN_W'(FLUSH_BUBBLES - 1);
        end else begin
          state_d   = RUN;
          drn_cnt_d = '0;
        end
      end
      (state_q == MUL_WAIT): begin
        ds_c = 1'b1;
        fs_c = 1'b1;
        if (mul_cnt_q <= MUL_W'(1)) begin
          state_d   = RUN;
          mul_cnt_d = '0;
        end else begin
          mul_cnt_d = mul_cnt_q - MUL_W'(1);
        end
      end
      (state_q == FLUSH_DRAIN): begin
        fs_c = 1'b1;
        if (drn_cnt_q <= DRN_W'(1)) begin
          state_d   = RUN;
          drn_cnt_d = '0;
        end else begin
          drn_cnt_d = drn_cnt_q - DRN_W'(1);
        end
      end
      (dec_valid & (rob_full | load_use)): begin
        fs_c = 1'b1;
      end
      dec_valid: begin
        dv_c = 1'b1;
        if (dec_is_mul && MUL_LATENCY > 1) begin
          state_d   = MUL_WAIT;
          mul_cnt_d = MUL_W'(MUL_LATENCY - 1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      mul_cnt_q <= '0;
      drn_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
      drn_cnt_q <= drn_cnt_d;
    end
  end

  // Reset forces every output low, even with live inputs.
  assign de_stall  = reset & ds_c;
  assign de_valid  = reset & dv_c;
  assign fd_stall  = reset & fs_c;
  assign rob_alloc = reset & dv_c;

`ifdef D_E_ISSUE_CTRL_PERF_EN
  localparam logic [PERF_CNT_W-1:0] SAT = '1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cycles <= '0;
      perf_bubbles      <= '0;
      perf_mul_wait     <= '0;
    end else begin
      if (fd_stall && perf_stall_cycles != SAT)
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (!de_valid && !de_stall && dec_valid
          && perf_bubbles != SAT)
        perf_bubbles <= perf_bubbles + 1'b1;
      if (state_q == MUL_WAIT && perf_mul_wait != SAT)
        perf_mul_wait <= perf_mul_wait + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_d_e_issue_ctrl.sv
// Self-checking bench for d_e_issue_ctrl.
// Vector table plus hand sequences, scoreboard queue.
module tb_d_e_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       dec_valid;
  logic [4:0] dec_rs1, dec_rs2;
  logic       dec_uses_rs1, dec_uses_rs2;
  logic       dec_is_mul;
  logic       ex_valid, ex_is_load;
  logic [4:0] ex_rd;
  logic       rob_full, flush;
  logic       de_stall, de_valid;
  logic       fd_stall, rob_alloc;
`ifdef D_E_ISSUE_CTRL_PERF_EN
  logic [31:0] p_stall, p_bub, p_mul;
`endif

  int pass_cnt = 0;
  int total    = 0;

  typedef struct {
    string      name;
    logic       dv;
    logic [4:0] r1, r2;
    logic       u1, u2, ml;
    logic       xv, xl;
    logic [4:0] xr;
    logic       rf, fl;
    logic [3:0] exp;
  } vec_t;

  logic [3:0] exp_q[$];
  string      name_q[$];
  vec_t       tbl[$];

  always #5 clk = ~clk;

  d_e_issue_ctrl #(
    .REG_ADDR_W   (5),
    .MUL_LATENCY  (5),
    .FLUSH_BUBBLES(2),
    .PERF_CNT_W   (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .dec_valid   (dec_valid),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_uses_rs1(dec_uses_rs1),
    .dec_uses_rs2(dec_uses_rs2),
    .dec_is_mul  (dec_is_mul),
    .ex_valid    (ex_valid),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .rob_full    (rob_full),
    .flush       (flush),
`ifdef D_E_ISSUE_CTRL_PERF_EN
    .perf_stall_cycles(p_stall),
    .perf_bubbles     (p_bub),
    .perf_mul_wait    (p_mul),
`endif
    .de_stall    (de_stall),
    .de_valid    (de_valid),
    .fd_stall    (fd_stall),
    .rob_alloc   (rob_alloc)
  );

  // exp bits: {de_stall, de_valid, fd_stall, rob_alloc}
  function automatic vec_t mk(
    string n, logic dv, logic [4:0] r1,
    logic [4:0] r2, logic u1, logic u2,
    logic ml, logic xv, logic xl,
    logic [4:0] xr, logic rf, logic fl,
    logic [3:0] e);
    vec_t v;
    v.name = n; v.dv = dv;
    v.r1 = r1; v.r2 = r2;
    v.u1 = u1; v.u2 = u2; v.ml = ml;
    v.xv = xv; v.xl = xl; v.xr = xr;
    v.rf = rf; v.fl = fl; v.exp = e;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    dec_valid    = v.dv;
    dec_rs1      = v.r1;
    dec_rs2      = v.r2;
    dec_uses_rs1 = v.u1;
    dec_uses_rs2 = v.u2;
    dec_is_mul   = v.ml;
    ex_valid     = v.xv;
    ex_is_load   = v.xl;
    ex_rd        = v.xr;
    rob_full     = v.rf;
    flush        = v.fl;
  endtask

  task automatic check_out();
    logic [3:0] got, e;
    string n;
    total++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard empty");
    end else begin
      got = {de_stall, de_valid,
             fd_stall, rob_alloc};
      e = exp_q.pop_front();
      n = name_q.pop_front();
      if (got !== e)
        $display("FAIL %s got=%b exp=%b",
                 n, got, e);
      else
        pass_cnt++;
    end
  endtask

  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    apply(v);
    exp_q.push_back(v.exp);
    name_q.push_back(v.name);
    #3;
    check_out();
  endtask

`ifdef D_E_ISSUE_CTRL_PERF_EN
  task automatic check_perf0(input string n);
    total++;
    if (p_stall !== 0 || p_bub !== 0
        || p_mul !== 0)
      $display("FAIL %s perf got=%0d/%0d/%0d exp=0",
               n, p_stall, p_bub, p_mul);
    else
      pass_cnt++;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    reset = 1'b0;
    apply(mk("init", 1, 1, 2, 1, 1, 0,
             0, 0, 0, 0, 0, 4'b0000));
    #2;
    exp_q.push_back(4'b0000);
    name_q.push_back("in_reset");
    check_out();
`ifdef D_E_ISSUE_CTRL_PERF_EN
    check_perf0("reset_perf");
`endif
    @(posedge clk);
    #2 reset = 1'b1;

    tbl.push_back(mk("plain_issue", 1, 1, 2, 1, 1,
      0, 0, 0, 0, 0, 0, 4'b0101));
    tbl.push_back(mk("lu_rs2", 1, 1, 5, 1, 1,
      0, 1, 1, 5, 0, 0, 4'b0010));
    tbl.push_back(mk("lu_rd0", 1, 0, 0, 1, 1,
      0, 1, 1, 0, 0, 0, 4'b0101));
    tbl.push_back(mk("lu_rs1", 1, 7, 3, 1, 0,
      0, 1, 1, 7, 0, 0, 4'b0010));
    tbl.push_back(mk("rs1_unused", 1, 7, 3, 0, 1,
      0, 1, 1, 7, 0, 0, 4'b0101));
    tbl.push_back(mk("not_load", 1, 7, 7, 1, 1,
      0, 1, 0, 7, 0, 0, 4'b0101));
    tbl.push_back(mk("ex_invalid", 1, 7, 7, 1, 1,
      0, 0, 1, 7, 0, 0, 4'b0101));
    tbl.push_back(mk("no_dec", 0, 7, 7, 1, 1,
      0, 1, 1, 7, 0, 0, 4'b0000));
    tbl.push_back(mk("rob_full", 1, 1, 2, 1, 1,
      0, 0, 0, 0, 1, 0, 4'b0010));
    tbl.push_back(mk("rob_and_lu", 1, 9, 2, 1, 1,
      0, 1, 1, 9, 1, 0, 4'b0010));
    tbl.push_back(mk("rs2_unused", 1, 1, 5, 1, 0,
      0, 1, 1, 5, 0, 0, 4'b0101));
    foreach (tbl[i]) step(tbl[i]);

    // load-use bubble then issue once load moves on
    step(mk("lu_seq0", 1, 1, 5, 0, 1,
      0, 1, 1, 5, 0, 0, 4'b0010));
    step(mk("lu_seq1", 1, 1, 5, 0, 1,
      0, 0, 0, 0, 0, 0, 4'b0101));

    // MUL holds execute 5 cycles in total
    step(mk("mul_issue", 1, 1, 2, 1, 1,
      1, 0, 0, 0, 0, 0, 4'b0101));
    for (int i = 0; i < 4; i++)
      step(mk($sformatf("mul_wait%0d", i),
        1, 3, 4, 1, 1, 0, 0, 0, 0, 0, 0,
        4'b1010));
    step(mk("mul_next", 1, 3, 4, 1, 1,
      0, 0, 0, 0, 0, 0, 4'b0101));

    // flush in second MUL_WAIT cycle
    step(mk("fm_issue", 1, 1, 2, 1, 1,
      1, 0, 0, 0, 0, 0, 4'b0101));
    step(mk("fm_wait0", 1, 3, 4, 1, 1,
      0, 0, 0, 0, 0, 0, 4'b1010));
    step(mk("fm_flush", 1, 3, 4, 1, 1,
      0, 0, 0, 0, 0, 1, 4'b0000));
    step(mk("fm_drain", 1, 3, 4, 1, 1,
      0, 0, 0, 0, 0, 0, 4'b0010));
    step(mk("fm_run", 1, 3, 4, 1, 1,
      0, 0, 0, 0, 0, 0, 4'b0101));

    // flush from RUN, then re-flush in drain
    step(mk("fr_flush", 1, 3, 4, 1, 1,
      0, 0, 0, 0, 0, 1, 4'b0000));
    step(mk("fr_reflush", 1, 3, 4, 1, 1,
      0, 0, 0, 0, 0, 1, 4'b0000));
    step(mk("fr_drain", 1, 3, 4, 1, 1,
      0, 0, 0, 0, 0, 0, 4'b0010));
    step(mk("fr_run", 1, 3, 4, 1, 1,
      0, 0, 0, 0, 0, 0, 4'b0101));

    // rob_full for 3 cycles
    for (int i = 0; i < 3; i++)
      step(mk($sformatf("rob_bub%0d", i),
        1, 1, 2, 1, 1, 0, 0, 0, 0, 1, 0,
        4'b0010));
    step(mk("rob_issue", 1, 1, 2, 1, 1,
      0, 0, 0, 0, 0, 0, 4'b0101));

    // async reset in the middle of MUL_WAIT
    step(mk("rm_issue", 1, 1, 2, 1, 1,
      1, 0, 0, 0, 0, 0, 4'b0101));
    step(mk("rm_wait0", 1, 3, 4, 1, 1,
      0, 0, 0, 0, 0, 0, 4'b1010));
    #1 reset = 1'b0;
    #1;
    exp_q.push_back(4'b0000);
    name_q.push_back("rm_in_reset");
    check_out();
`ifdef D_E_ISSUE_CTRL_PERF_EN
    check_perf0("rm_perf");
`endif
    @(posedge clk);
    #2 reset = 1'b1;
    step(mk("rm_run", 1, 3, 4, 1, 1,
      0, 0, 0, 0, 0, 0, 4'b0101));

    $display("%0d/%0d checks passed",
             pass_cnt, total);
    $finish;
  end

endmodule
